ball_motion_ctrl: RTL and testbench



---
 rtl/ball_motion_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_ball_motion_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_motion_ctrl.sv
// Frame-rate motion sequencer for the bouncing ball: owns position, direction and
// game state, steps the ball once per frame while running and reports wall bounces.
module ball_motion_ctrl #(
    parameter int p_H_VISIBLE    = 640,
    parameter int p_V_VISIBLE    = 480,
    parameter int p_BALL_SIZE    = 10,
    parameter int p_SERVE_FRAMES = 60
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_VReset,
    input  logic       i_Start,
    input  logic       i_Pause,
    output logic [1:0] o_State,
    output logic [9:0] o_PosX,
    output logic [8:0] o_PosY,
    output logic       o_XDir,
    output logic       o_YDir,
    output logic       o_Step,
    output logic       o_Bounce,
    output logic       o_Corner,
    output logic [7:0] o_BounceCount
);
    localparam logic [9:0] MAXX = 10'(p_H_VISIBLE - p_BALL_SIZE + 1);
    localparam logic [8:0] MAXY = 9'(p_V_VISIBLE - p_BALL_SIZE + 1);
    localparam logic [9:0] CX   = 10'(p_H_VISIBLE / 2 - p_BALL_SIZE / 2 + 1);
    localparam logic [8:0] CY   = 9'(p_V_VISIBLE / 2 - p_BALL_SIZE / 2 + 1);
    localparam int         SCW  = $clog2(p_SERVE_FRAMES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SERVE = 2'b01,
        S_RUN   = 2'b10,
        S_PAUSE = 2'b11
    } state_t;

    state_t           r_State, w_State;
    logic [9:0]       r_PosX, w_PosX, w_XStep;
    logic [8:0]       r_PosY, w_PosY, w_YStep;
    logic             r_XDir, w_XDir, w_XFlip;
    logic             r_YDir, w_YDir, w_YFlip;
    logic             r_Step, w_Step;
    logic             r_Bounce, w_Bounce;
    logic             r_Corner, w_Corner;
    logic [7:0]       r_BounceCount, w_BounceCount;
    logic             r_SrvTgl, w_SrvTgl;
    logic [SCW-1:0]   r_SrvCnt, w_SrvCnt;

    // Candidate next position per axis; reflecting off a wall lands one pixel inside.
    always_comb begin
        w_XFlip = 1'b0;
        w_XStep = r_PosX;
        if (!r_XDir) begin
            if (r_PosX == MAXX) begin
                w_XFlip = 1'b1;
                w_XStep = MAXX - 10'd1;
            end else begin
                w_XStep = r_PosX + 10'd1;
            end
        end else begin
            if (r_PosX == 10'd1) begin
                w_XFlip = 1'b1;
                w_XStep = 10'd2;
            end else begin
                w_XStep = r_PosX - 10'd1;
            end
        end
    end

    always_comb begin
        w_YFlip = 1'b0;
        w_YStep = r_PosY;
        if (!r_YDir) begin
            if (r_PosY == MAXY) begin
                w_YFlip = 1'b1;
                w_YStep = MAXY - 9'd1;
            end else begin
                w_YStep = r_PosY + 9'd1;
            end
        end else begin
            if (r_PosY == 9'd1) begin
                w_YFlip = 1'b1;
                w_YStep = 9'd2;
            end else begin
                w_YStep = r_PosY - 9'd1;
            end
        end
    end

    always_comb begin
        w_State       = r_State;
        w_PosX        = r_PosX;
        w_PosY        = r_PosY;
        w_XDir        = r_XDir;
        w_YDir        = r_YDir;
        w_Step        = 1'b0;
        w_Bounce      = 1'b0;
        w_Corner      = 1'b0;
        w_BounceCount = r_BounceCount;
        w_SrvTgl      = r_SrvTgl;
        w_SrvCnt      = r_SrvCnt;
        // A serve request overrides everything; serve direction alternates each time.
        if (i_Start) begin
            w_State       = S_SERVE;
            w_PosX        = CX;
            w_PosY        = CY;
            w_XDir        = r_SrvTgl;
            w_YDir        = 1'b0;
            w_SrvTgl      = ~r_SrvTgl;
            w_SrvCnt      = '0;
            w_BounceCount = 8'd0;
        end else begin
            case (r_State)
                S_SERVE: begin
                    if (!i_Pause && i_VReset) begin
                        w_SrvCnt = r_SrvCnt + 1'b1;
                        if (w_SrvCnt == SCW'(p_SERVE_FRAMES))
                            w_State = S_RUN;
                    end
                end
                S_RUN: begin
                    if (i_Pause) begin
                        w_State = S_PAUSE;
                    end else if (i_VReset) begin
                        w_PosX   = w_XStep;
                        w_PosY   = w_YStep;
                        w_XDir   = r_XDir ^ w_XFlip;
                        w_YDir   = r_YDir ^ w_YFlip;
                        w_Step   = 1'b1;
                        w_Bounce = w_XFlip | w_YFlip;
                        w_Corner = w_XFlip & w_YFlip;
                        if (w_Bounce && r_BounceCount != 8'hFF)
                            w_BounceCount = r_BounceCount + 8'd1;
                    end
                end
                S_PAUSE: begin
                    if (!i_Pause)
                        w_State = S_RUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_State       <= S_IDLE;
            r_PosX        <= CX;
            r_PosY        <= CY;
            r_XDir        <= 1'b0;
            r_YDir        <= 1'b0;
            r_Step        <= 1'b0;
            r_Bounce      <= 1'b0;
            r_Corner      <= 1'b0;
            r_BounceCount <= 8'd0;
            r_SrvTgl      <= 1'b0;
            r_SrvCnt      <= '0;
        end else begin
            r_State       <= w_State;
            r_PosX        <= w_PosX;
            r_PosY        <= w_PosY;
            r_XDir        <= w_XDir;
            r_YDir        <= w_YDir;
            r_Step        <= w_Step;
            r_Bounce      <= w_Bounce;
            r_Corner      <= w_Corner;
            r_BounceCount <= w_BounceCount;
            r_SrvTgl      <= w_SrvTgl;
            r_SrvCnt      <= w_SrvCnt;
        end
    end

    assign o_State       = r_State;
    assign o_PosX        = r_PosX;
    assign o_PosY        = r_PosY;
    assign o_XDir        = r_XDir;
    assign o_YDir        = r_YDir;
    assign o_Step        = r_Step;
    assign o_Bounce      = r_Bounce;
    assign o_Corner      = r_Corner;
    assign o_BounceCount = r_BounceCount;
endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Bench for ball_motion_ctrl: a full-size instance (A) and a tiny-screen instance (B)
// share clock/reset/frame/pause; a behavioural model feeds a per-cycle scoreboard.
module tb_ball_motion_ctrl;
    localparam int MXA = 631, MYA = 471, CXA = 316, CYA = 236, SFA = 3;
    localparam int MXB = 11,  MYB = 11,  CXB = 6,   CYB = 6,   SFB = 1;

    typedef struct {
        int st; int x; int y;
        bit xd; bit yd; bit stp; bit bnc; bit cor;
        int cnt; bit tog; int sc;
    } mdl_t;

    logic       clk = 1'b0, rst = 1'b1, vr = 1'b0, pa = 1'b0, stA = 1'b0, stB = 1'b0;
    logic [1:0] oStA, oStB;
    logic [9:0] oXA, oXB;
    logic [8:0] oYA, oYB;
    logic       oXdA, oYdA, oStpA, oBncA, oCorA, oXdB, oYdB, oStpB, oBncB, oCorB;
    logic [7:0] oCntA, oCntB;

    int   errs = 0, checks = 0;
    bit   pause = 1'b0;
    mdl_t mA, mB;
    logic [67:0] q[$];

    ball_motion_ctrl #(.p_H_VISIBLE(640), .p_V_VISIBLE(480), .p_BALL_SIZE(10), .p_SERVE_FRAMES(SFA)) dutA (
        .i_Clk(clk), .i_Reset(rst), .i_VReset(vr), .i_Start(stA), .i_Pause(pa),
        .o_State(oStA), .o_PosX(oXA), .o_PosY(oYA), .o_XDir(oXdA), .o_YDir(oYdA),
        .o_Step(oStpA), .o_Bounce(oBncA), .o_Corner(oCorA), .o_BounceCount(oCntA));

    ball_motion_ctrl #(.p_H_VISIBLE(20), .p_V_VISIBLE(20), .p_BALL_SIZE(10), .p_SERVE_FRAMES(SFB)) dutB (
        .i_Clk(clk), .i_Reset(rst), .i_VReset(vr), .i_Start(stB), .i_Pause(pa),
        .o_State(oStB), .o_PosX(oXB), .o_PosY(oYB), .o_XDir(oXdB), .o_YDir(oYdB),
        .o_Step(oStpB), .o_Bounce(oBncB), .o_Corner(oCorB), .o_BounceCount(oCntB));

    always #5 clk = ~clk;

    function automatic mdl_t mreset(int cx, int cy);
        mdl_t m;
        m.st = 0; m.x = cx; m.y = cy; m.xd = 0; m.yd = 0;
        m.stp = 0; m.bnc = 0; m.cor = 0; m.cnt = 0; m.tog = 0; m.sc = 0;
        return m;
    endfunction

    function automatic mdl_t mstep(mdl_t m, bit st, bit p, bit v, int mx, int my, int cx, int cy, int sf);
        mdl_t n = m;
        bit fx = 0, fy = 0;
        n.stp = 0; n.bnc = 0; n.cor = 0;
        if (st) begin
            n.st = 1; n.x = cx; n.y = cy; n.cnt = 0; n.xd = m.tog; n.tog = !m.tog; n.yd = 0; n.sc = 0;
        end else if (m.st == 1) begin
            if (!p && v) begin
                n.sc = m.sc + 1;
                if (n.sc == sf) n.st = 2;
            end
        end else if (m.st == 2) begin
            if (p) n.st = 3;
            else if (v) begin
                if (!m.xd) begin if (m.x == mx) begin n.x = mx - 1; fx = 1; end else n.x = m.x + 1; end
                else       begin if (m.x == 1)  begin n.x = 2;      fx = 1; end else n.x = m.x - 1; end
                if (!m.yd) begin if (m.y == my) begin n.y = my - 1; fy = 1; end else n.y = m.y + 1; end
                else       begin if (m.y == 1)  begin n.y = 2;      fy = 1; end else n.y = m.y - 1; end
                if (fx) n.xd = !m.xd;
                if (fy) n.yd = !m.yd;
                n.stp = 1; n.bnc = fx | fy; n.cor = fx & fy;
                if (n.bnc && n.cnt < 255) n.cnt = m.cnt + 1;
            end
        end else if (m.st == 3) begin
            if (!p) n.st = 2;
        end
        return n;
    endfunction

    function automatic logic [33:0] pack(mdl_t m);
        return {2'(m.st), 10'(m.x), 9'(m.y), m.xd, m.yd, m.stp, m.bnc, m.cor, 8'(m.cnt)};
    endfunction

    // One clock of stimulus; the expected post-edge outputs go onto the scoreboard.
    task automatic drive(input bit sa, input bit sb, input bit v);
        @(negedge clk);
        stA = sa; stB = sb; vr = v; pa = pause;
        if (rst) begin
            mA = mreset(CXA, CYA); mB = mreset(CXB, CYB);
        end else begin
            mA = mstep(mA, sa, pause, v, MXA, MYA, CXA, CYA, SFA);
            mB = mstep(mB, sb, pause, v, MXB, MYB, CXB, CYB, SFB);
        end
        q.push_back({pack(mA), pack(mB)});
    endtask

    task automatic tick();  drive(0, 0, 0); endtask
    task automatic frame(); drive(0, 0, 1); tick(); endtask

    always @(posedge clk) begin
        logic [67:0] e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if ({oStA, oXA, oYA, oXdA, oYdA, oStpA, oBncA, oCorA, oCntA,
                 oStB, oXB, oYB, oXdB, oYdB, oStpB, oBncB, oCorB, oCntB} !== e) begin
                errs++;
                $display("FAIL scoreboard t=%0t got A=%h B=%h expected A=%h B=%h", $time,
                    {oStA, oXA, oYA, oXdA, oYdA, oStpA, oBncA, oCorA, oCntA},
                    {oStB, oXB, oYB, oXdB, oYdB, oStpB, oBncB, oCorB, oCntB}, e[67:34], e[33:0]);
            end
        end
    end

    task automatic test_reset();
        int steps = 0;
        mA = mreset(CXA, CYA); mB = mreset(CXB, CYB);
        tick(); tick();
        checks++;
        if (oStA !== 2'b00 || oXA !== 10'd316 || oYA !== 9'd236 || oCntA !== 8'd0) begin
            errs++; $display("FAIL reset_values got st=%0d x=%0d y=%0d cnt=%0d expected 0/316/236/0", oStA, oXA, oYA, oCntA);
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            frame();
            steps += oStpA;
        end
        checks++;
        if (oStA !== 2'b00 || oXA !== 10'd316 || oYA !== 9'd236 || steps != 0) begin
            errs++; $display("FAIL idle_frames got st=%0d x=%0d y=%0d steps=%0d expected 0/316/236/0", oStA, oXA, oYA, steps);
        end
    endtask

    task automatic test_serve();
        drive(1, 0, 0); tick();
        checks++;
        if (oStA !== 2'b01 || oXdA !== 1'b0) begin
            errs++; $display("FAIL serve_start got st=%0d xdir=%0d expected 1/0", oStA, oXdA);
        end
        frame(); frame();
        checks++;
        if (oStA !== 2'b01) begin errs++; $display("FAIL serve_hold got st=%0d expected 1", oStA); end
        frame();
        checks++;
        if (oStA !== 2'b10 || oXA !== 10'd316 || oStpA !== 1'b0) begin
            errs++; $display("FAIL serve_to_run got st=%0d x=%0d step=%0d expected 2/316/0", oStA, oXA, oStpA);
        end
        frame();
        checks++;
        if (oStpA !== 1'b1 || oXA !== 10'd317 || oYA !== 9'd237 || oXdA !== 1'b0) begin
            errs++; $display("FAIL first_step got step=%0d x=%0d y=%0d xdir=%0d expected 1/317/237/0", oStpA, oXA, oYA, oXdA);
        end
    endtask

    task automatic test_run_bounce();
        int bnc = 0;
        for (int k = 2; k <= 317; k++) begin
            frame();
            bnc += oBncA;
            if (k == 236) begin
                checks++;
                if (oYA !== 9'd470 || oYdA !== 1'b1 || oBncA !== 1'b1) begin
                    errs++; $display("FAIL y_bounce got y=%0d ydir=%0d bounce=%0d expected 470/1/1", oYA, oYdA, oBncA);
                end
            end
            if (k == 316) begin
                checks++;
                if (oXA !== 10'd630 || oXdA !== 1'b1 || oBncA !== 1'b1 || oCorA !== 1'b0) begin
                    errs++; $display("FAIL x_bounce got x=%0d xdir=%0d bounce=%0d corner=%0d expected 630/1/1/0", oXA, oXdA, oBncA, oCorA);
                end
            end
        end
        checks++;
        if (oXA !== 10'd629 || oYA !== 9'd389 || oCntA !== 8'd2 || bnc != 2) begin
            errs++; $display("FAIL run_end got x=%0d y=%0d cnt=%0d pulses=%0d expected 629/389/2/2", oXA, oYA, oCntA, bnc);
        end
    endtask

    task automatic test_pause();
        int steps = 0;
        pause = 1'b1;
        frame();
        checks++;
        if (oStA !== 2'b11 || oXA !== 10'd629 || oStpA !== 1'b0) begin
            errs++; $display("FAIL pause_enter got st=%0d x=%0d step=%0d expected 3/629/0", oStA, oXA, oStpA);
        end
        for (int i = 0; i < 5; i++) begin frame(); steps += oStpA; end
        checks++;
        if (oStA !== 2'b11 || oXA !== 10'd629 || oYA !== 9'd389 || steps != 0) begin
            errs++; $display("FAIL pause_hold got st=%0d x=%0d y=%0d steps=%0d expected 3/629/389/0", oStA, oXA, oYA, steps);
        end
        pause = 1'b0;
        tick(); tick();
        checks++;
        if (oStA !== 2'b10) begin errs++; $display("FAIL pause_release got st=%0d expected 2", oStA); end
        frame();
        checks++;
        if (oStpA !== 1'b1 || oXA !== 10'd628 || oYA !== 9'd388) begin
            errs++; $display("FAIL resume_step got step=%0d x=%0d y=%0d expected 1/628/388", oStpA, oXA, oYA);
        end
    endtask

    task automatic test_restart_reset();
        drive(1, 0, 0); tick();
        checks++;
        if (oStA !== 2'b01 || oXA !== 10'd316 || oCntA !== 8'd0 || oXdA !== 1'b1) begin
            errs++; $display("FAIL second_serve got st=%0d x=%0d cnt=%0d xdir=%0d expected 1/316/0/1", oStA, oXA, oCntA, oXdA);
        end
        frame();
        drive(0, 0, 1);
        @(posedge clk); #3;
        rst = 1'b1;
        mA = mreset(CXA, CYA); mB = mreset(CXB, CYB);
        #1;
        checks++;
        if (oStA !== 2'b00 || oXA !== 10'd316 || oYA !== 9'd236 || oXdA !== 1'b0 || oYdA !== 1'b0 ||
            oStpA !== 1'b0 || oBncA !== 1'b0 || oCorA !== 1'b0 || oCntA !== 8'd0) begin
            errs++; $display("FAIL async_reset got st=%0d x=%0d y=%0d xd=%0d yd=%0d expected 0/316/236/0/0", oStA, oXA, oYA, oXdA, oYdA);
        end
        tick(); tick();
        @(negedge clk); rst = 1'b0;
        frame();
        checks++;
        if (oStA !== 2'b00 || oStpA !== 1'b0 || oXA !== 10'd316) begin
            errs++; $display("FAIL post_reset got st=%0d step=%0d x=%0d expected 0/0/316", oStA, oStpA, oXA);
        end
    endtask

    task automatic test_corner();
        drive(0, 1, 0); tick();
        frame();
        checks++;
        if (oStB !== 2'b10 || oXB !== 10'd6) begin
            errs++; $display("FAIL small_serve got st=%0d x=%0d expected 2/6", oStB, oXB);
        end
        for (int k = 1; k <= 5; k++) frame();
        checks++;
        if (oXB !== 10'd11 || oYB !== 9'd11 || oBncB !== 1'b0) begin
            errs++; $display("FAIL pre_corner got x=%0d y=%0d bounce=%0d expected 11/11/0", oXB, oYB, oBncB);
        end
        frame();
        checks++;
        if (oXB !== 10'd10 || oYB !== 9'd10 || oXdB !== 1'b1 || oYdB !== 1'b1 ||
            oBncB !== 1'b1 || oCorB !== 1'b1 || oCntB !== 8'd1) begin
            errs++; $display("FAIL corner got x=%0d y=%0d xd=%0d yd=%0d b=%0d c=%0d cnt=%0d expected 10/10/1/1/1/1/1",
                oXB, oYB, oXdB, oYdB, oBncB, oCorB, oCntB);
        end
        tick();
        checks++;
        if (oCorB !== 1'b0 || oBncB !== 1'b0) begin
            errs++; $display("FAIL corner_pulse got b=%0d c=%0d expected 0/0", oBncB, oCorB);
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_run_bounce();
        test_pause();
        test_restart_reset();
        test_corner();
        tick(); tick();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
